// File: rtl/div_sched.sv
// div_sched: round-robin scheduler sharing one divider between two requesters.
// Defining DIV_SCHED_REUSE_EN answers an exact repeat of the last completed operation without the divider.
`ifndef XLEN
`define XLEN 32
`endif
module div_sched #(
  parameter int XLEN = `XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op,
  input  logic [1:0]        req_word,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [1:0]        flush,
  output logic [1:0]        resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              div_start,
  output logic [1:0]        div_op,
  output logic              div_word,
  output logic [XLEN-1:0]   div_dividend,
  output logic [XLEN-1:0]   div_divisor,
  input  logic              div_busy,
  input  logic              div_ready,
  input  logic [XLEN-1:0]   div_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic rr, kill, owner, grant, fire, hit, idle;
  logic [1:0] sel_op;
  logic sel_word;
  logic [XLEN-1:0] sel_a, sel_b, hit_data;
  assign grant = (req_valid == 2'b11) ? rr : req_valid[1];
  assign idle = (state == IDLE) && !div_busy;
  assign req_ready = idle ? ({grant, !grant} & req_valid & ~flush) : 2'b00;
  assign fire = |(req_valid & req_ready);
  assign sel_op = grant ? req_op[3:2] : req_op[1:0];
  assign sel_word = req_word[grant];
  assign sel_a = grant ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
  assign sel_b = grant ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
`ifdef DIV_SCHED_REUSE_EN
  logic c_valid, c_word;
  logic [1:0] c_op;
  logic [XLEN-1:0] c_a, c_b, c_res;
  assign hit = c_valid && c_op == sel_op && c_word == sel_word && c_a == sel_a && c_b == sel_b;
  assign hit_data = c_res;
  // killed operations still refresh the entry: the divider did finish them
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_valid <= 1'b0;
      c_op <= '0;
      c_word <= 1'b0;
      c_a <= '0;
      c_b <= '0;
      c_res <= '0;
    end else if (state == WAIT && div_ready) begin
      c_valid <= 1'b1;
      c_op <= div_op;
      c_word <= div_word;
      c_a <= div_dividend;
      c_b <= div_divisor;
      c_res <= div_result;
    end
  end
`else
  assign hit = 1'b0;
  assign hit_data = '0;
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      rr <= 1'b0;
      kill <= 1'b0;
      owner <= 1'b0;
      div_start <= 1'b0;
      div_op <= '0;
      div_word <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      resp_valid <= '0;
      resp_data <= '0;
    end else begin
      div_start <= 1'b0;
      resp_valid <= 2'b00;
      if (state != IDLE && flush[owner]) kill <= 1'b1;
      case (state)
        IDLE: if (fire) begin
          owner <= grant;
          rr <= !grant;
          kill <= 1'b0;
          div_op <= sel_op;
          div_word <= sel_word;
          div_dividend <= sel_a;
          div_divisor <= sel_b;
          div_start <= !hit;
          resp_valid <= hit ? {grant, !grant} : 2'b00;
          if (hit) resp_data <= hit_data;
          state <= hit ? RESP : ISSUE;
        end
        ISSUE: state <= WAIT;
        // a flush arriving with div_ready still suppresses this response
        WAIT: if (div_ready) begin
          resp_data <= div_result;
          resp_valid <= (kill || flush[owner]) ? 2'b00 : {owner, !owner};
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed scenarios plus randomized traffic against a behavioural scheduler/divider model.
module tb_div_sched;
  localparam int XLEN = 32;
  logic clk = 1'b0, reset_n;
  logic [1:0] req_valid, req_ready, req_word, flush, resp_valid, div_op;
  logic [3:0] req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] resp_data, div_dividend, div_divisor, div_result;
  logic div_start, div_word, div_busy, div_ready;
  logic m_busy = 1'b0, hold_busy = 1'b0;
  int checks = 0, errors = 0, d_fix = 3, c = 0;
  logic [1:0] acc, s_rv, s_rdy;
  logic [31:0] s_rd, s_dd, s_dv;
  logic s_ds;
  logic pend = 1'b0, p_own, p_word, p_hit, p_kill, m_rr = 1'b0;
  logic [1:0] p_op;
  logic [31:0] p_a, p_b, p_exp;
  int p_hs, p_end;
`ifdef DIV_SCHED_REUSE_EN
  logic cv = 1'b0, cword;
  logic [1:0] cop;
  logic [31:0] ca, cb;
`endif
  assign div_busy = m_busy | hold_busy;
  always #5 clk = ~clk;
  div_sched #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_data(resp_data), .div_start(div_start), .div_op(div_op),
    .div_word(div_word), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_ready(div_ready), .div_result(div_result)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  // RISC-V M-extension divide semantics; op[0] selects unsigned, op[1] selects remainder
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, r;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (op[0]) return op[1] ? a % b : a / b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    r = op[1] ? sa % sb : sa / sb;
    return r;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd100;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  // divider model: result D cycles after the start pulse, busy meanwhile
  initial begin
    int cnt;
    logic st, rs;
    logic [31:0] res;
    cnt = 0;
    res = 0;
    div_ready = 1'b0;
    div_result = '0;
    forever begin
      @(negedge clk);
      st = div_start;
      rs = !reset_n;
      @(posedge clk);
      #1;
      div_ready = 1'b0;
      if (rs) begin
        cnt = 0;
        m_busy = 1'b0;
      end else begin
        if (st) begin
          cnt = d_fix > 0 ? d_fix : int'($urandom_range(1, 5));
          m_busy = 1'b1;
          res = ref_div(div_op, div_dividend, div_divisor);
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            div_ready = 1'b1;
            m_busy = 1'b0;
            div_result = res;
          end
        end
      end
    end
  end
  // scoreboard: one outstanding operation, predicted from the request at its handshake
  always @(negedge clk) begin
    logic [1:0] hs, er;
    logic g;
    c++;
    if (!reset_n) begin
      pend = 1'b0;
      m_rr = 1'b0;
`ifdef DIV_SCHED_REUSE_EN
      cv = 1'b0;
`endif
    end else begin
      g = (req_valid == 2'b11) ? m_rr : req_valid[1];
      er = (pend || div_busy) ? 2'b00 : ((g ? 2'b10 : 2'b01) & req_valid & ~flush);
      check("req_ready", req_ready, er);
      check("div_start", div_start, pend && !p_hit && c == p_hs + 1);
      if (div_start && pend) begin
        check("div_dividend", div_dividend, p_a);
        check("div_divisor", div_divisor, p_b);
        check("div_op", div_op, p_op);
        check("div_word", div_word, p_word);
      end
      if (pend && c > p_hs && (p_end < 0 || c < p_end) && flush[p_own]) p_kill = 1'b1;
      if (pend && !p_hit && p_end < 0 && c > p_hs + 1 && div_ready) begin
        p_end = c + 1;
`ifdef DIV_SCHED_REUSE_EN
        cv = 1'b1;
        cop = p_op;
        cword = p_word;
        ca = p_a;
        cb = p_b;
`endif
      end
      if (pend && c == p_end) begin
        check("resp_valid", resp_valid, p_kill ? 2'b00 : (p_own ? 2'b10 : 2'b01));
        if (!p_kill) check("resp_data", resp_data, p_exp);
        pend = 1'b0;
      end else if (resp_valid != 2'b00) check("resp_spurious", resp_valid, 2'b00);
      if (pend && c - p_hs > 200) begin
        check("resp_timeout", c - p_hs, 0);
        pend = 1'b0;
      end
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        p_own = hs[1];
        p_op = p_own ? req_op[3:2] : req_op[1:0];
        p_word = req_word[p_own];
        p_a = p_own ? req_a[63:32] : req_a[31:0];
        p_b = p_own ? req_b[63:32] : req_b[31:0];
        p_exp = ref_div(p_op, p_a, p_b);
        p_hit = 1'b0;
`ifdef DIV_SCHED_REUSE_EN
        p_hit = cv && cop == p_op && cword == p_word && ca == p_a && cb == p_b;
`endif
        p_end = p_hit ? c + 1 : -1;
        p_kill = 1'b0;
        p_hs = c;
        m_rr = !p_own;
        pend = 1'b1;
      end
    end
  end
  task automatic cyc();
    @(negedge clk);
    acc = req_valid & req_ready;
    s_rv = resp_valid;
    s_rd = resp_data;
    s_rdy = req_ready;
    s_ds = div_start;
    s_dd = div_dividend;
    s_dv = div_divisor;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask
  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*2 +: 2] = op;
    req_word[i] = 1'b0;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
  endtask
  task automatic wait_resp(input int lim, output logic [1:0] v, output logic [31:0] d, output int n);
    v = 2'b00;
    d = '0;
    n = 0;
    while (v == 2'b00 && n < lim) begin
      cyc();
      n++;
      if (s_rv != 2'b00) begin
        v = s_rv;
        d = s_rd;
      end
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [1:0] v;
    logic [31:0] d;
    int n, ks;
    reset_n = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_word = '0;
    req_a = '0;
    req_b = '0;
    flush = '0;
    repeat (3) cyc();
    check("rst_resp_valid", s_rv, 0);
    check("rst_resp_data", s_rd, 0);
    check("rst_req_ready", s_rdy, 0);
    check("rst_div_start", s_ds, 0);
    check("rst_dividend", s_dd, 0);
    check("rst_divisor", s_dv, 0);
    reset_n = 1'b1;
    set_req(0, 2'b11, 100, 7);
    set_req(1, 2'b01, 9, 3);
    cyc();
    check("cont_grant", s_rdy, 2'b01);
    wait_resp(100, v, d, n);
    check("cont_first_owner", v, 2'b01);
    check("cont_first_data", d, 2);
    wait_resp(100, v, d, n);
    check("cont_second_owner", v, 2'b10);
    check("cont_second_data", d, 3);
    set_req(0, 2'b11, 100, 7);
    set_req(1, 2'b01, 9, 3);
    cyc();
    check("cont_rr_back_to_0", s_rdy, 2'b01);
    req_valid = 2'b00;
    wait_resp(100, v, d, n);
    d_fix = 33;
    set_req(0, 2'b00, 100, 7);
    cyc();
    check("div_hs", s_rdy, 2'b01);
    ks = 0;
    v = 2'b00;
    n = 0;
    while (v == 2'b00 && n < 60) begin
      cyc();
      n++;
      if (s_ds) ks = n;
      if (s_rv != 2'b00) begin
        v = s_rv;
        d = s_rd;
      end
    end
    check("div_start_lat", ks, 1);
    check("div_resp_lat", n, 35);
    check("div_resp_owner", v, 2'b01);
    check("div_resp_data", d, 14);
    d_fix = 10;
    set_req(1, 2'b00, 50, 5);
    cyc();
    check("flush_hs", s_rdy, 2'b10);
    repeat (3) cyc();
    flush = 2'b10;
    cyc();
    flush = 2'b00;
    wait_resp(30, v, d, n);
    check("flush_no_resp", v, 2'b00);
    set_req(1, 2'b00, 50, 5);
    cyc();
    check("flush_next_hs", s_rdy, 2'b10);
    wait_resp(40, v, d, n);
    check("flush_next_owner", v, 2'b10);
    check("flush_next_data", d, 10);
    d_fix = 3;
    hold_busy = 1'b1;
    set_req(0, 2'b01, 77, 8);
    repeat (5) begin
      cyc();
      check("busy_gate", s_rdy, 2'b00);
    end
    hold_busy = 1'b0;
    cyc();
    check("busy_release", s_rdy, 2'b01);
    wait_resp(40, v, d, n);
    check("busy_data", d, 9);
    d_fix = 0;
    for (int i = 0; i < 2500; i++) begin
      req_valid = 2'($urandom);
      req_op = 4'($urandom);
      req_word = 2'($urandom);
      for (int r = 0; r < 2; r++) begin
        req_a[r*32 +: 32] = pick();
        req_b[r*32 +: 32] = pick();
      end
      flush = {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0};
      hold_busy = $urandom_range(0, 15) == 0;
      cyc();
    end
    req_valid = 2'b00;
    flush = 2'b00;
    hold_busy = 1'b0;
    repeat (20) cyc();
    d_fix = 20;
    set_req(0, 2'b00, 100, 7);
    cyc();
    check("mid_hs", s_rdy, 2'b01);
    repeat (5) cyc();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    check("mid_rst_resp_valid", s_rv, 0);
    check("mid_rst_div_start", s_ds, 0);
    check("mid_rst_resp_data", s_rd, 0);
    check("mid_rst_dividend", s_dd, 0);
    check("mid_rst_divisor", s_dv, 0);
    check("mid_rst_req_ready", s_rdy, 0);
    set_req(0, 2'b00, 100, 7);
    set_req(1, 2'b00, 100, 7);
    cyc();
    check("mid_rst_rr", s_rdy, 2'b01);
    req_valid = 2'b00;
    wait_resp(60, v, d, n);
    check("mid_rst_after_data", d, 14);
`ifdef DIV_SCHED_REUSE_EN
    d_fix = 5;
    set_req(0, 2'b00, -20, 3);
    cyc();
    wait_resp(40, v, d, n);
    check("reuse_first_data", d, 32'hFFFF_FFFA);
    set_req(0, 2'b00, -20, 3);
    cyc();
    check("reuse_hs", s_rdy, 2'b01);
    cyc();
    check("reuse_hit_valid", s_rv, 2'b01);
    check("reuse_hit_data", s_rd, 32'hFFFF_FFFA);
    check("reuse_no_start", s_ds, 0);
    set_req(0, 2'b00, -20, 4);
    cyc();
    ks = 0;
    v = 2'b00;
    n = 0;
    while (v == 2'b00 && n < 40) begin
      cyc();
      n++;
      if (s_ds) ks = n;
      if (s_rv != 2'b00) begin
        v = s_rv;
        d = s_rd;
      end
    end
    check("reuse_miss_start", ks, 1);
    check("reuse_miss_data", d, 32'hFFFF_FFFB);
`endif
    repeat (5) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
